control_multiciclo: RTL and testbench

//  Multicycle control FSM sequencing the processor datapath: IR/PC load, register file, ALU,

---
 rtl/ctrl_pkg.sv | 85 ++++++++
 rtl/control_salidas.sv | 88 ++++++++
 rtl/control_multiciclo.sv | 114 +++++++++++
 tb/tb_control_multiciclo.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, datapath mux selects
// and the packed control word that the output decoder produces.
package ctrl_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_MEM,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_BRANCH,
        S_JUMP
    } state_t;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2,
        ALU_IMM   = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_RT      = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SH2 = 2'd3
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JUMP   = 2'd2,
        PC_RSVD   = 2'd3
    } pc_src_t;

    typedef struct packed {
        logic       pc_we;
        logic       pc_we_cond;
        pc_src_t    pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_we;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        logic       ext_sel;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    // Logical immediates take a zero-extended imm16; arithmetic ones sign-extend.
    function automatic logic is_zero_ext(input logic [OPC_W-1:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_salidas.sv
// Output decoder of the multicycle controller: maps current state (plus opcode for the
// immediate-extension select and illegal detection, and mem_ready for strobe completion).
module control_salidas
    import ctrl_pkg::*;
(
    input  state_t           state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output ctrl_t            ctrl
);

    always_comb begin
        // NOTE: the all-zero default covers every field in every branch, so no latch is inferred.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_we     = mem_ready;
                ctrl.pc_we     = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.ext_sel   = 1'b1;
                if (!is_legal(opcode)) begin
                    ctrl.illegal_op = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_sel   = 1'b1;
            end
            S_MEM_RD: begin
                ctrl.mem_rd = 1'b1;
                ctrl.iord   = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_wr     = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_WB_MEM: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_WB_R: begin
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_IMM;
                ctrl.ext_sel   = !is_zero_ext(opcode);
            end
            S_WB_I: begin
                // Extender select stays put so the datapath sees a stable immediate.
                ctrl.reg_we     = 1'b1;
                ctrl.ext_sel    = !is_zero_ext(opcode);
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_RT;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_we_cond = 1'b1;
                ctrl.pc_src     = PC_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_we      = 1'b1;
                ctrl.pc_src     = PC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB sequencing of the datapath.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counter outputs.
module control_multiciclo
    import ctrl_pkg::*;
#(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_we,
    output logic            pc_we_cond,
    output logic [1:0]      pc_src,
    output logic            iord,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            ir_we,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_we,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            ext_sel,
    output logic            illegal_op,
    output logic            instr_done
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t state;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl_out;

    // The datapath ANDs zero with pc_we_cond itself; the flag is only carried on this port.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:                        state <= S_MEM_ADDR;
                        OP_RTYPE:                            state <= S_EXEC_R;
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   state <= S_EXEC_I;
                        OP_BEQ:                              state <= S_BRANCH;
                        OP_J:                                state <= S_JUMP;
                        default:                             state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem_ready) state <= S_WB_MEM;
                S_MEM_WR:   if (mem_ready) state <= S_FETCH;
                S_EXEC_R:   state <= S_WB_R;
                S_EXEC_I:   state <= S_WB_I;
                default:    state <= S_FETCH;
            endcase
        end
    end

    control_salidas u_salidas (
        .state     (state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_dec)
    );

    // Reset forces every strobe low in the reset cycle, even when aborting mid-instruction.
    assign ctrl_out = rst ? '0 : ctrl_dec;

    assign pc_we      = ctrl_out.pc_we;
    assign pc_we_cond = ctrl_out.pc_we_cond;
    assign pc_src     = ctrl_out.pc_src;
    assign iord       = ctrl_out.iord;
    assign mem_rd     = ctrl_out.mem_rd;
    assign mem_wr     = ctrl_out.mem_wr;
    assign ir_we      = ctrl_out.ir_we;
    assign reg_dst    = ctrl_out.reg_dst;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign reg_we     = ctrl_out.reg_we;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign alu_op     = ctrl_out.alu_op;
    assign ext_sel    = ctrl_out.ext_sel;
    assign illegal_op = ctrl_out.illegal_op;
    assign instr_done = ctrl_out.instr_done;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (ctrl_out.instr_done) instr_cnt <= instr_cnt + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: per-state control words hand-derived from the
// instruction flows, compared cycle by cycle for every instruction class and reset case.
module tb_control_multiciclo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b000000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_we, pc_we_cond, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we;
    logic       alu_src_a, ext_sel, illegal_op, instr_done;
    logic [1:0] pc_src, alu_src_b, alu_op;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    control_multiciclo dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .pc_we_cond (pc_we_cond),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_we      (ir_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_we     (reg_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .ext_sel    (ext_sel),
        .illegal_op (illegal_op),
        .instr_done (instr_done)
    );

    // Field order: pc_we pc_we_cond pc_src[2] iord mem_rd mem_wr ir_we reg_dst mem_to_reg
    //              reg_we alu_src_a alu_src_b[2] alu_op[2] ext_sel illegal_op instr_done
    logic [18:0] obs;
    assign obs = {pc_we, pc_we_cond, pc_src, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg,
                  reg_we, alu_src_a, alu_src_b, alu_op, ext_sel, illegal_op, instr_done};

    localparam logic [18:0] E_ZERO     = 19'd0;
    localparam logic [18:0] E_FETCH    = {1'b1,1'b0,2'd0, 1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 2'd1,2'd0, 1'b0,1'b0,1'b0};
    localparam logic [18:0] E_FETCH_W  = {1'b0,1'b0,2'd0, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 2'd1,2'd0, 1'b0,1'b0,1'b0};
    localparam logic [18:0] E_DECODE   = {1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 2'd3,2'd0, 1'b1,1'b0,1'b0};
    localparam logic [18:0] E_ILLEGAL  = {1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 2'd3,2'd0, 1'b1,1'b1,1'b1};
    localparam logic [18:0] E_MEM_ADDR = {1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, 2'd2,2'd0, 1'b1,1'b0,1'b0};
    localparam logic [18:0] E_MEM_RD   = {1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0, 1'b0,1'b0,1'b0};
    localparam logic [18:0] E_MEM_WR_W = {1'b0,1'b0,2'd0, 1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0, 1'b0,1'b0,1'b0};
    localparam logic [18:0] E_MEM_WR_D = {1'b0,1'b0,2'd0, 1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0, 1'b0,1'b0,1'b1};
    localparam logic [18:0] E_WB_MEM   = {1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0, 2'd0,2'd0, 1'b0,1'b0,1'b1};
    localparam logic [18:0] E_EXEC_R   = {1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, 2'd0,2'd2, 1'b0,1'b0,1'b0};
    localparam logic [18:0] E_WB_R     = {1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 2'd0,2'd0, 1'b0,1'b0,1'b1};
    localparam logic [18:0] E_EXEC_I_S = {1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, 2'd2,2'd3, 1'b1,1'b0,1'b0};
    localparam logic [18:0] E_EXEC_I_Z = {1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, 2'd2,2'd3, 1'b0,1'b0,1'b0};
    localparam logic [18:0] E_WB_I_S   = {1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 2'd0,2'd0, 1'b1,1'b0,1'b1};
    localparam logic [18:0] E_WB_I_Z   = {1'b0,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 2'd0,2'd0, 1'b0,1'b0,1'b1};
    localparam logic [18:0] E_BRANCH   = {1'b0,1'b1,2'd1, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, 2'd0,2'd1, 1'b0,1'b0,1'b1};
    localparam logic [18:0] E_JUMP     = {1'b1,1'b0,2'd2, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0, 1'b0,1'b0,1'b1};

    localparam logic [5:0] OPX   = 6'b111111;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] JMP   = 6'b000010;

    // Each task starts on a falling edge with the FSM in FETCH and returns the same way.
    task automatic test_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (obs !== E_ZERO) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got %b want %b", i, obs, E_ZERO);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== E_FETCH) begin
            miscompares++;
            $display("FAIL first_fetch: got %b want %b", obs, E_FETCH);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_r_type();
        logic [5:0]  ops [4];
        logic        rdy [4];
        logic [18:0] ex  [4];
        ops = '{OPX, RTYPE, RTYPE, RTYPE};
        ex  = '{E_FETCH, E_DECODE, E_EXEC_R, E_WB_R};
        for (int pass = 0; pass < 2; pass++) begin
            // Second pass drops mem_ready outside FETCH: non-memory states must ignore it.
            rdy = (pass == 0) ? '{1'b1, 1'b1, 1'b1, 1'b1} : '{1'b1, 1'b0, 1'b0, 1'b0};
            for (int i = 0; i < 4; i++) begin
                opcode = ops[i];
                mem_ready = rdy[i];
                #1;
                vectors++;
                if (obs !== ex[i]) begin
                    miscompares++;
                    $display("FAIL r_type pass %0d step %0d: got %b want %b", pass, i, obs, ex[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [5:0]  ops [7];
        logic        rdy [7];
        logic [18:0] ex  [7];
        int          done_at;
        ops = '{OPX, LW, LW, LW, LW, LW, LW};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ex  = '{E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_RD, E_MEM_RD, E_MEM_RD, E_WB_MEM};
        done_at = 0;
        for (int i = 0; i < 7; i++) begin
            opcode = ops[i];
            mem_ready = rdy[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                miscompares++;
                $display("FAIL lw_wait step %0d: got %b want %b", i, obs, ex[i]);
            end
            if (instr_done === 1'b1 && done_at == 0) done_at = i + 1;
            @(negedge clk);
        end
        vectors++;
        if (done_at != 7) begin
            miscompares++;
            $display("FAIL lw_cpi: got %0d cycles want 7", done_at);
        end
    endtask

    task automatic test_sw_fetch_wait();
        logic [5:0]  ops [6];
        logic        rdy [6];
        logic [18:0] ex  [6];
        ops = '{OPX, OPX, SW, SW, SW, SW};
        rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ex  = '{E_FETCH_W, E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_WR_W, E_MEM_WR_D};
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            mem_ready = rdy[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                miscompares++;
                $display("FAIL sw_wait step %0d: got %b want %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_beq();
        logic [5:0]  ops [3];
        logic        rdy [3];
        logic [18:0] ex  [3];
        ops = '{OPX, BEQ, BEQ};
        rdy = '{1'b1, 1'b0, 1'b1};
        ex  = '{E_FETCH, E_DECODE, E_BRANCH};
        for (int z = 1; z >= 0; z--) begin
            zero = (z == 1);
            for (int i = 0; i < 3; i++) begin
                opcode = ops[i];
                mem_ready = rdy[i];
                #1;
                vectors++;
                if (obs !== ex[i]) begin
                    miscompares++;
                    $display("FAIL beq zero=%0d step %0d: got %b want %b", z, i, obs, ex[i]);
                end
                @(negedge clk);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [5:0]  ops [3];
        logic        rdy [3];
        logic [18:0] ex  [3];
        ops = '{OPX, JMP, JMP};
        rdy = '{1'b1, 1'b1, 1'b0};
        ex  = '{E_FETCH, E_DECODE, E_JUMP};
        for (int i = 0; i < 3; i++) begin
            opcode = ops[i];
            mem_ready = rdy[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                miscompares++;
                $display("FAIL jump step %0d: got %b want %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_imm_ext();
        logic [5:0]  imm_ops [4];
        logic [18:0] ex_exec [4];
        logic [18:0] ex_wb   [4];
        logic [18:0] ex      [4];
        // andi, addi, ori, slti
        imm_ops = '{6'b001100, 6'b001000, 6'b001101, 6'b001010};
        ex_exec = '{E_EXEC_I_Z, E_EXEC_I_S, E_EXEC_I_Z, E_EXEC_I_S};
        ex_wb   = '{E_WB_I_Z, E_WB_I_S, E_WB_I_Z, E_WB_I_S};
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ex = '{E_FETCH, E_DECODE, ex_exec[k], ex_wb[k]};
            for (int i = 0; i < 4; i++) begin
                opcode = (i == 0) ? OPX : imm_ops[k];
                #1;
                vectors++;
                if (obs !== ex[i]) begin
                    miscompares++;
                    $display("FAIL imm op=%b step %0d: got %b want %b", imm_ops[k], i, obs, ex[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  bad [2];
        logic [18:0] ex  [3];
        logic        rdy [3];
        bad = '{6'b111111, 6'b100000};
        ex  = '{E_FETCH, E_ILLEGAL, E_FETCH_W};
        rdy = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                opcode = (i == 1) ? bad[k] : OPX;
                mem_ready = rdy[i];
                #1;
                vectors++;
                if (obs !== ex[i]) begin
                    miscompares++;
                    $display("FAIL illegal op=%b step %0d: got %b want %b", bad[k], i, obs, ex[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_in_mem_wr();
        logic [5:0]  ops [4];
        logic        rdy [4];
        logic [18:0] ex  [4];
        ops = '{OPX, SW, SW, SW};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
        ex  = '{E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_WR_W};
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            mem_ready = rdy[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                miscompares++;
                $display("FAIL rst_mem_wr step %0d: got %b want %b", i, obs, ex[i]);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (obs !== E_ZERO) begin
            miscompares++;
            $display("FAIL rst_mem_wr abort: got %b want %b", obs, E_ZERO);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== E_FETCH) begin
            miscompares++;
            $display("FAIL rst_mem_wr refetch: got %b want %b", obs, E_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_wait();
        test_sw_fetch_wait();
        test_beq();
        test_jump();
        test_imm_ext();
        test_illegal();
        test_reset_in_mem_wr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
